// File: rtl/fft_bram_pkg.sv
// Shared types and constants for the FFT bin to BRAM writer.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
package fft_bram_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    UNPACK     = 2'd1,
    WAIT_START = 2'd2
  } state_e;

  // Default configuration: 8 channels of 24-bit complex samples into 32-bit words
  localparam int DEF_NUM_CH    = 8;
  localparam int DEF_SAMPLE_W  = 24;
  localparam int DEF_OUT_W     = 32;
  localparam int DEF_FFT_LEN   = 256;
  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_ADDR_STEP = 4;

  // Widest word the sign extender can produce
  localparam int SEXT_MAX_W = 64;

  // Replicate bit src_w-1 of val into every bit above it (result is SEXT_MAX_W wide)
  function automatic logic [SEXT_MAX_W-1:0] sign_extend(input logic [SEXT_MAX_W-1:0] val,
                                                        input int src_w);
    logic [SEXT_MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      res[i] = (i < src_w) ? val[i] : val[src_w-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_beat_unpacker.sv
// Holds one accepted multi-channel beat and emits the sign-extended re/im of a selected channel.
// Latency: combinational from sel_i; beat register loads on load_i (channel 0 bypasses from beat_i).
// Backpressure: none; the parent only asserts load_i on an accepted beat.
module fft_beat_unpacker
  import fft_bram_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_i,
  input  logic [NUM_CH*2*SAMPLE_W-1:0] beat_i,
  input  logic [CH_W-1:0]              sel_i,
  output logic [OUT_W-1:0]             re_o,
  output logic [OUT_W-1:0]             im_o
);

  localparam int BEAT_W = NUM_CH * 2 * SAMPLE_W;

  logic [BEAT_W-1:0]   beat_q;
  logic [BEAT_W-1:0]   beat_d;
  logic [BEAT_W-1:0]   src;
  logic [SAMPLE_W-1:0] re_raw;
  logic [SAMPLE_W-1:0] im_raw;

  // Capture the beat on acceptance, otherwise hold it for the remaining channels
  always_comb begin
    beat_d = load_i ? beat_i : beat_q;
  end

  // Beat storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  // Channel mux: on the accept cycle read the live beat so channel 0 can be written immediately
  always_comb begin
    src    = load_i ? beat_i : beat_q;
    re_raw = src[int'(sel_i)*2*SAMPLE_W +: SAMPLE_W];
    im_raw = src[int'(sel_i)*2*SAMPLE_W + SAMPLE_W +: SAMPLE_W];
    re_o   = OUT_W'(sign_extend(SEXT_MAX_W'(re_raw), SAMPLE_W));
    im_o   = OUT_W'(sign_extend(SEXT_MAX_W'(im_raw), SAMPLE_W));
  end

endmodule

// File: rtl/fft_bin_bram_writer.sv
// Serialises one AXI-Stream FFT bin beat (NUM_CH complex samples) into NUM_CH BRAM writes; optional ping-pong banks via FFT_BIN_BRAM_PINGPONG_EN.
// Latency: writes appear 1..NUM_CH cycles after accept; finish pulses one cycle after the last write of a frame.
// Backpressure: tready only in IDLE (one beat per NUM_CH+1 cycles); after a frame it stalls until start unless ping-pong is built in.
module fft_bin_bram_writer
  import fft_bram_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int FFT_LEN   = DEF_FFT_LEN,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ADDR_STEP = DEF_ADDR_STEP
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_CH*2*SAMPLE_W-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [ADDR_W-1:0]            bram_addr,
  output logic [OUT_W-1:0]             bram_din_re,
  output logic [OUT_W-1:0]             bram_din_im,
  output logic [OUT_W/8-1:0]           bram_we,
  output logic                         bram_en,
  output logic                         bram_rst,
  output logic                         bank_sel,
  output logic                         finish,
  output logic                         tlast_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIN_W = $clog2(FFT_LEN);
  localparam longint FRAME_BYTES = longint'(FFT_LEN) * longint'(NUM_CH) * longint'(ADDR_STEP);
`ifdef FFT_BIN_BRAM_PINGPONG_EN
  localparam longint BANK_BYTES = longint'(1) << (ADDR_W - 1);
`else
  localparam longint BANK_BYTES = longint'(1) << ADDR_W;
`endif

  // Elaboration-time parameter sanity
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be >= 1");
  end
  if (FFT_LEN < 2) begin : g_bad_fft_len
    $error("FFT_LEN must be >= 2");
  end
  if ((OUT_W < SAMPLE_W) || (OUT_W % 8 != 0) || (OUT_W > SEXT_MAX_W)) begin : g_bad_out_w
    $error("OUT_W must be >= SAMPLE_W, a multiple of 8 and <= 64");
  end
  if (FRAME_BYTES > BANK_BYTES) begin : g_bad_addr_space
    $error("frame does not fit in the BRAM address space");
  end

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_cnt_q, bin_cnt_d;
  logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [OUT_W-1:0]    din_re_q, din_re_d;
  logic [OUT_W-1:0]    din_im_q, din_im_d;
  logic                we_q, we_d;
  logic                finish_q, finish_d;
  logic                tlast_err_q, tlast_err_d;
`ifdef FFT_BIN_BRAM_PINGPONG_EN
  logic                bank_sel_q, bank_sel_d;
`endif

  logic                unp_load;
  logic [CH_W-1:0]     unp_sel;
  logic [OUT_W-1:0]    unp_re;
  logic [OUT_W-1:0]    unp_im;
  logic [CH_W-1:0]     ch_nxt;
  logic                bin_is_last;
  logic                ch_is_last;

  // Linear bin-major byte address, wrapping in ADDR_W bits
  function automatic logic [ADDR_W-1:0] wr_addr(input logic [BIN_W-1:0] bin,
                                                input logic [CH_W-1:0]  ch);
    return (ADDR_W'(bin) * ADDR_W'(NUM_CH) + ADDR_W'(ch)) * ADDR_W'(ADDR_STEP);
  endfunction

  fft_beat_unpacker #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W),
    .CH_W     (CH_W)
  ) u_unpack (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (unp_load),
    .beat_i (s_axis_tdata),
    .sel_i  (unp_sel),
    .re_o   (unp_re),
    .im_o   (unp_im)
  );

  assign ch_nxt      = ch_cnt_q + CH_W'(1);
  assign bin_is_last = (bin_cnt_q == BIN_W'(FFT_LEN - 1));
  assign ch_is_last  = (ch_cnt_q == CH_W'(NUM_CH - 1));

  // Next-state: accept a beat in IDLE, walk its channels in UNPACK, count bins per frame
  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    bram_addr_d = bram_addr_q;
    din_re_d    = din_re_q;
    din_im_d    = din_im_q;
    we_d        = 1'b0;
    finish_d    = 1'b0;
    tlast_err_d = start ? 1'b0 : tlast_err_q;
    unp_load    = 1'b0;
    unp_sel     = '0;
`ifdef FFT_BIN_BRAM_PINGPONG_EN
    bank_sel_d  = bank_sel_q;
`endif

    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          // Channel 0 is written straight from the live beat on the accept edge
          unp_load    = 1'b1;
          ch_cnt_d    = '0;
          we_d        = 1'b1;
          din_re_d    = unp_re;
          din_im_d    = unp_im;
          bram_addr_d = wr_addr(bin_cnt_q, '0);
          // Framing check; the frame length still follows the bin counter
          if (s_axis_tlast != bin_is_last) begin
            tlast_err_d = 1'b1;
          end
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        if (ch_is_last) begin
          if (bin_is_last) begin
            bin_cnt_d = '0;
            finish_d  = 1'b1;
`ifdef FFT_BIN_BRAM_PINGPONG_EN
            bank_sel_d = ~bank_sel_q;
            state_d    = IDLE;
`else
            state_d    = WAIT_START;
`endif
          end else begin
            bin_cnt_d = bin_cnt_q + BIN_W'(1);
            state_d   = IDLE;
          end
        end else begin
          unp_sel     = ch_nxt;
          ch_cnt_d    = ch_nxt;
          we_d        = 1'b1;
          din_re_d    = unp_re;
          din_im_d    = unp_im;
          bram_addr_d = wr_addr(bin_cnt_q, ch_nxt);
        end
      end

      WAIT_START: begin
        if (start) begin
          state_d     = IDLE;
          bram_addr_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef FFT_BIN_BRAM_PINGPONG_EN
    // Top address bit selects the bank currently being filled
    if (we_d) begin
      bram_addr_d[ADDR_W-1] = bank_sel_q;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      bram_addr_q <= '0;
      din_re_q    <= '0;
      din_im_q    <= '0;
      we_q        <= 1'b0;
      finish_q    <= 1'b0;
      tlast_err_q <= 1'b0;
`ifdef FFT_BIN_BRAM_PINGPONG_EN
      bank_sel_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      bram_addr_q <= bram_addr_d;
      din_re_q    <= din_re_d;
      din_im_q    <= din_im_d;
      we_q        <= we_d;
      finish_q    <= finish_d;
      tlast_err_q <= tlast_err_d;
`ifdef FFT_BIN_BRAM_PINGPONG_EN
      bank_sel_q  <= bank_sel_d;
`endif
    end
  end

  assign s_axis_tready = (state_q == IDLE);
  assign bram_addr     = bram_addr_q;
  assign bram_din_re   = din_re_q;
  assign bram_din_im   = din_im_q;
  assign bram_we       = {(OUT_W/8){we_q}};
  assign bram_en       = 1'b1;
  assign bram_rst      = ~rst_n;
  assign finish        = finish_q;
  assign tlast_err     = tlast_err_q;
`ifdef FFT_BIN_BRAM_PINGPONG_EN
  assign bank_sel      = bank_sel_q;
`else
  assign bank_sel      = 1'b0;
`endif

endmodule

// File: tb/tb_fft_bin_bram_writer.sv
// Scoreboard bench for fft_bin_bram_writer: default config (u0) and a small config (u1).
module tb_fft_bin_bram_writer;

`ifdef FFT_BIN_BRAM_PINGPONG_EN
  localparam int AW0 = 14;
`else
  localparam int AW0 = 13;
`endif

  typedef struct {
    bit          fin;
    logic [13:0] addr;
    logic [31:0] re;
    logic [31:0] im;
  } exp_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0: defaults
  logic           rst_n, start0, tvalid0, tlast0, tready0;
  logic [383:0]   tdata0;
  logic [AW0-1:0] addr0;
  logic [31:0]    re0, im0;
  logic [3:0]     we0;
  logic           en0, brst0, bank0, fin0, err0;

  // u1: NUM_CH=4, SAMPLE_W=16, FFT_LEN=8, ADDR_W=8
  logic           rst1_n, start1, tvalid1, tlast1, tready1;
  logic [127:0]   tdata1;
  logic [7:0]     addr1;
  logic [31:0]    re1, im1;
  logic [3:0]     we1;
  logic           en1, brst1, bank1, fin1, err1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic exp_bank0 = 1'b0;
  logic exp_bank1 = 1'b0;

  fft_bin_bram_writer #(
    .NUM_CH(8), .SAMPLE_W(24), .OUT_W(32), .FFT_LEN(256), .ADDR_W(AW0), .ADDR_STEP(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .s_axis_tdata(tdata0), .s_axis_tvalid(tvalid0), .s_axis_tlast(tlast0), .s_axis_tready(tready0),
    .bram_addr(addr0), .bram_din_re(re0), .bram_din_im(im0), .bram_we(we0),
    .bram_en(en0), .bram_rst(brst0), .bank_sel(bank0), .finish(fin0), .tlast_err(err0)
  );

  fft_bin_bram_writer #(
    .NUM_CH(4), .SAMPLE_W(16), .OUT_W(32), .FFT_LEN(8), .ADDR_W(8), .ADDR_STEP(4)
  ) u1 (
    .clk(clk), .rst_n(rst1_n), .start(start1),
    .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1), .s_axis_tlast(tlast1), .s_axis_tready(tready1),
    .bram_addr(addr1), .bram_din_re(re1), .bram_din_im(im1), .bram_we(we1),
    .bram_en(en1), .bram_rst(brst1), .bank_sel(bank1), .finish(fin1), .tlast_err(err1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor u0: every write or finish pulse consumes the next scoreboard entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (we0 != 4'h0) begin
        check("u0_we_all_ones", 64'(we0), 64'hF);
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL u0_unexpected_write: got addr %0h, expected no write", addr0);
        end else begin
          e0 = q0.pop_front();
          check("u0_entry_is_write", 64'(e0.fin), 64'd0);
          check("u0_addr", 64'(addr0), 64'(e0.addr));
          check("u0_din_re", 64'(re0), 64'(e0.re));
          check("u0_din_im", 64'(im0), 64'(e0.im));
        end
      end
      if (fin0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL u0_unexpected_finish: got finish=1, expected 0");
        end else begin
          e0 = q0.pop_front();
          check("u0_finish_slot", 64'(e0.fin), 64'd1);
        end
      end
    end
  end

  // Monitor u1
  always @(negedge clk) begin
    if (rst1_n) begin
      if (we1 != 4'h0) begin
        check("u1_we_all_ones", 64'(we1), 64'hF);
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL u1_unexpected_write: got addr %0h, expected no write", addr1);
        end else begin
          e1 = q1.pop_front();
          check("u1_entry_is_write", 64'(e1.fin), 64'd0);
          check("u1_addr", 64'(addr1), 64'(e1.addr));
          check("u1_din_re", 64'(re1), 64'(e1.re));
          check("u1_din_im", 64'(im1), 64'(e1.im));
        end
      end
      if (fin1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL u1_unexpected_finish: got finish=1, expected 0");
        end else begin
          e1 = q1.pop_front();
          check("u1_finish_slot", 64'(e1.fin), 64'd1);
        end
      end
    end
  end

  // Beat for u0: bin 0 in "const" mode uses re=c+1, im=-(c+1) with literal expectations
  task automatic mk_beat0(input int b, input bit cst, output logic [383:0] d,
                          output logic [31:0] er[8], output logic [31:0] ei[8]);
    logic [23:0] r, i;
    d = '0;
    for (int c = 0; c < 8; c++) begin
      if (cst) begin
        r = 24'(c + 1);
        i = 24'hFFFFFF - 24'(c);
        er[c] = 32'(c + 1);
        ei[c] = 32'hFFFFFFFF - 32'(c);
      end else begin
        r = 24'(b * 256 + c * 17 + 3);
        i = 24'h800000 + 24'(b * 3 + c);
        er[c] = {{8{r[23]}}, r};
        ei[c] = {{8{i[23]}}, i};
      end
      d[c*48 +: 24]      = r;
      d[c*48 + 24 +: 24] = i;
    end
  endtask

  task automatic send0(input logic [383:0] d, input logic last, input int b,
                       input logic [31:0] er[8], input logic [31:0] ei[8]);
    int n;
    logic [AW0-1:0] a;
    @(negedge clk);
    tdata0 = d; tlast0 = last; tvalid0 = 1'b1;
    n = 0;
    while (!tready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tready0) begin
      total++; bad++;
      $display("FAIL u0_send_timeout: got tready=0 for %0d cycles, expected 1", n);
      tvalid0 = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      a = AW0'((b * 8 + c) * 4);
`ifdef FFT_BIN_BRAM_PINGPONG_EN
      a[AW0-1] = exp_bank0;
`endif
      q0.push_back('{fin: 1'b0, addr: 14'(a), re: er[c], im: ei[c]});
    end
    if (b == 255) q0.push_back('{fin: 1'b1, addr: 14'd0, re: 32'd0, im: 32'd0});
    #1;
  endtask

  // Streams bins b0..b1 with tvalid held high; tlast on bin 255 and on err_bin
  task automatic frame0(input int b0, input int b1, input int err_bin);
    logic [383:0] d;
    logic [31:0]  er[8];
    logic [31:0]  ei[8];
    for (int b = b0; b <= b1; b++) begin
      mk_beat0(b, 1'b0, d, er, ei);
      send0(d, (b == 255) || (b == err_bin), b, er, ei);
    end
    tvalid0 = 1'b0;
  endtask

  task automatic wait_fin0(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!fin0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(fin0), 64'd1);
  endtask

  task automatic chk_reset0(input string tag);
    check({tag, "_tready"}, 64'(tready0), 64'd1);
    check({tag, "_we"},     64'(we0),     64'd0);
    check({tag, "_addr"},   64'(addr0),   64'd0);
    check({tag, "_re"},     64'(re0),     64'd0);
    check({tag, "_im"},     64'(im0),     64'd0);
    check({tag, "_finish"}, 64'(fin0),    64'd0);
    check({tag, "_err"},    64'(err0),    64'd0);
    check({tag, "_bank"},   64'(bank0),   64'd0);
  endtask

  task automatic send1(input int b);
    logic [15:0] r, i;
    logic [7:0]  a;
    int n;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      r = (b == 0 && c == 0) ? 16'h8000 : 16'(b * 16 + c + 1);
      i = 16'hF000 | 16'(b * 4 + c);
      tdata1[c*32 +: 16]      = r;
      tdata1[c*32 + 16 +: 16] = i;
    end
    tlast1 = (b == 7); tvalid1 = 1'b1;
    n = 0;
    while (!tready1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tready1) begin
      total++; bad++;
      $display("FAIL u1_send_timeout: got tready=0 for %0d cycles, expected 1", n);
      tvalid1 = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      r = tdata1[c*32 +: 16];
      i = tdata1[c*32 + 16 +: 16];
      a = 8'((b * 4 + c) * 4);
`ifdef FFT_BIN_BRAM_PINGPONG_EN
      a[7] = exp_bank1;
`endif
      q1.push_back('{fin: 1'b0, addr: 14'(a),
                     re: (b == 0 && c == 0) ? 32'hFFFF8000 : {{16{r[15]}}, r},
                     im: {{16{i[15]}}, i}});
    end
    if (b == 7) q1.push_back('{fin: 1'b1, addr: 14'd0, re: 32'd0, im: 32'd0});
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [383:0] d;
    logic [31:0]  er[8];
    logic [31:0]  ei[8];
    int n;
    bit stayed_low;

    rst_n = 1'b0; rst1_n = 1'b0;
    start0 = 1'b0; tvalid0 = 1'b0; tlast0 = 1'b0; tdata0 = '0;
    start1 = 1'b0; tvalid1 = 1'b0; tlast1 = 1'b0; tdata1 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk_reset0("rst");
    check("rst_bram_rst", 64'(brst0), 64'd1);
    check("rst_bram_en",  64'(en0),   64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);
    check("run_bram_rst", 64'(brst0), 64'd0);

    // One beat with hand-computed data; tready low for NUM_CH cycles afterwards
    mk_beat0(0, 1'b1, d, er, ei);
    send0(d, 1'b0, 0, er, ei);
    tvalid0 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!tready0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("tready_low_cycles", 64'(n), 64'd8);

    // Rest of frame A: last write at 8188, single finish, then stall until start
    frame0(1, 255, -1);
    wait_fin0("frameA_finish");
    exp_bank0 = ~exp_bank0;
`ifdef FFT_BIN_BRAM_PINGPONG_EN
    check("frameA_bank", 64'(bank0), 64'(exp_bank0));
    check("frameA_no_stall", 64'(tready0), 64'd1);
`else
    exp_bank0 = 1'b0;
    check("frameA_bank", 64'(bank0), 64'd0);
    stayed_low = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (tready0) stayed_low = 1'b0;
      @(negedge clk);
    end
    check("frameA_tready_held_low", 64'(stayed_low), 64'd1);
`endif
    check("frameA_err", 64'(err0), 64'd0);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;

    // Frame B: early tlast on bin 10 sets sticky error; frame still runs 256 bins
    frame0(0, 10, 10);
    check("frameB_err_set", 64'(err0), 64'd1);
    frame0(11, 255, 10);
    wait_fin0("frameB_finish");
`ifdef FFT_BIN_BRAM_PINGPONG_EN
    exp_bank0 = ~exp_bank0;
`endif
    check("frameB_bank", 64'(bank0), 64'(exp_bank0));
    check("frameB_err_sticky", 64'(err0), 64'd1);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check("frameB_err_cleared", 64'(err0), 64'd0);

    // Frame C: reset during channel 3 of bin 5
    frame0(0, 4, -1);
    mk_beat0(5, 1'b0, d, er, ei);
    send0(d, 1'b0, 5, er, ei);
    tvalid0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    q0.delete();
    exp_bank0 = 1'b0;
    #1;
    chk_reset0("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame D restarts at address 0 and must not produce a finish
    mk_beat0(0, 1'b0, d, er, ei);
    send0(d, 1'b0, 0, er, ei);
    tvalid0 = 1'b0;
    repeat (15) @(negedge clk);
    check("frameD_bank", 64'(bank0), 64'd0);

    // Small configuration: 32 writes over 0..124, 0x8000 sign-extends to 0xFFFF8000
    for (int b = 0; b < 8; b++) send1(b);
    tvalid1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!fin1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("u1_finish", 64'(fin1), 64'd1);
`ifdef FFT_BIN_BRAM_PINGPONG_EN
    exp_bank1 = 1'b1;
`endif
    check("u1_bank", 64'(bank1), 64'(exp_bank1));
    check("u1_err", 64'(err1), 64'd0);

    repeat (5) @(negedge clk);
    check("u0_scoreboard_empty", 64'(q0.size()), 64'd0);
    check("u1_scoreboard_empty", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_bin_bram_writer.md
Name: fft_bin_bram_writer

Overview:
Parametrised successor to the FFT-output BRAM controller. Accepts one AXI-Stream beat per FFT bin, each carrying NUM_CH complex samples, and serialises it into NUM_CH consecutive BRAM writes with sign extension. Counts FFT_LEN bins per frame, pulses finish, then holds off the stream until start. Sits between the multi-channel FFT core and the dual-port spectrum BRAM read by the downstream beamformer/CPU.

Parameters:
NUM_CH, 8, channels (complex samples) per input beat; must be >= 1
SAMPLE_W, 24, width of each real/imag field in the input beat
OUT_W, 32, BRAM word width; must be >= SAMPLE_W and a multiple of 8
FFT_LEN, 256, bins per frame; must be >= 2
ADDR_W, 13, BRAM byte-address width
ADDR_STEP, 4, byte-address increment per write (OUT_W/8)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  re-arm after finish; clears tlast_err
s_axis_tdata  in  NUM_CH*2*SAMPLE_W  channel c: re at [c*2*SAMPLE_W +: SAMPLE_W], im directly above
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last bin of frame
s_axis_tready  out  1  beat accept
bram_addr  out  ADDR_W  byte address
bram_din_re  out  OUT_W  sign-extended real part
bram_din_im  out  OUT_W  sign-extended imag part
bram_we  out  OUT_W/8  byte write enables, all ones or all zeros
bram_en  out  1  tied 1
bram_rst  out  1  equals ~rst_n
bank_sel  out  1  current ping-pong bank (0 unless feature compiled in)
finish  out  1  one-cycle frame-complete pulse
tlast_err  out  1  sticky framing error

Behaviour:
- Reset: state IDLE, bin_cnt=0, ch_cnt=0, bram_addr=0, din_re/im=0, bram_we=0, finish=0, tlast_err=0, bank_sel=0. Reset mid-frame abandons the frame; no partial finish.
- States: IDLE, UNPACK, WAIT_START. s_axis_tready = (state==IDLE), combinational from the state register only.
- IDLE: on tvalid&tready (cycle T), latch tdata and tlast, set ch_cnt=0, go to UNPACK.
- UNPACK: each cycle, register channel ch_cnt sign-extended to OUT_W. bram_we is all ones, bram_addr = ((bin_cnt*NUM_CH)+ch_cnt)*ADDR_STEP (linear bin-major layout). Writes are visible in cycles T+1..T+NUM_CH. Throughput is one beat per NUM_CH+1 cycles.
- Last channel (ch_cnt==NUM_CH-1):
  - If bin_cnt==FFT_LEN-1: bin_cnt->0, finish=1 for exactly one cycle (T+NUM_CH+1), go to WAIT_START.
  - Else: bin_cnt++, go to IDLE.
- bram_we=0 whenever not writing.
- WAIT_START: tready=0. start -> IDLE next cycle, address base reset. start in other states is ignored, except that it clears tlast_err in any state.
- tlast check on each accepted beat: tlast=1 with bin_cnt!=FFT_LEN-1, or tlast=0 with bin_cnt==FFT_LEN-1, sets tlast_err. The frame length is still governed by the FFT_LEN count. If start clear and error set coincide, set wins.
- Address arithmetic is done in ADDR_W bits and wraps modulo 2^ADDR_W. Elaboration check: FFT_LEN*NUM_CH*ADDR_STEP <= 2^ADDR_W (halved space when PINGPONG).

Optional Feature:
Macro FFT_BIN_BRAM_PINGPONG_EN.
- Defined: bram_addr MSB = bank_sel, and the lower ADDR_W-1 bits follow the layout above. bank_sel toggles on each finish. WAIT_START is skipped: after finish, go directly to IDLE, so the next frame streams into the other bank with no stall; start only clears tlast_err.
- Undefined: bank_sel is constant 0, full ADDR_W linear space is used, and the block stalls in WAIT_START as above.

Decomposition:
- Package fft_bram_pkg: state enum (IDLE/UNPACK/WAIT_START), default parameter constants, sign_extend function (SAMPLE_W to OUT_W).
- One natural sub-module: fft_beat_unpacker, holding the beat register and a channel mux that emits the sign-extended re/im for the selected channel. The top level keeps the FSM, counters, address generation and error logic.

Test Plan:
- Defaults, one beat, ch c re=c+1, im=-(c+1) -> 8 writes at addr 0,4,...,28; din_re=1..8; din_im=0xFFFFFFFF..0xFFFFFFF8; tready low 8 cycles.
- Full frame of 256 beats with tvalid held high, tlast on beat 255 -> last write at addr 8188, single finish pulse, tready stays 0 until start, tlast_err=0.
- tlast asserted on bin 10 -> tlast_err=1 and stays set; frame still ends after 256 beats; start clears it.
- rst_n dropped mid-UNPACK at ch 3 of bin 5 -> all outputs return to reset values; next frame begins at addr 0 with no finish pulse.
- NUM_CH=4, SAMPLE_W=16, FFT_LEN=8, ADDR_W=8 -> 32 writes covering addr 0..124; re field 0x8000 written as 0xFFFF8000.
- With FFT_BIN_BRAM_PINGPONG_EN and two back-to-back frames -> frame 0 at addr MSB 0, frame 1 at MSB 1, bank_sel toggles at each finish, no WAIT_START stall.
